instr_encoder: RTL and testbench

- Packs instruction fields (op, rd, rs1, rs2, funct3, funct7, immediate) into one 19-bit instruction word per pkgs opcode class, checks that the immediate is representable, and writes accepted words sequentially into instruction memory.
- Used by the boot/program loader and the test infrastructure to fill imem for the 19-bit CPU. It is the exact inverse of the core's instruction decode field layout.

---
 rtl/instr_encoder.sv | 204 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs instruction fields into 19-bit words and streams legal words into imem.
// Optional build macro INSTR_ENCODER_CHECKSUM_EN adds csum_o (XOR of written words).
//
// state | meaning
// IDLE  | waiting for start_i
// LOAD  | accepting field sets, encoding and range-checking combinationally
// WRITE | holding imem_we_o/addr/data until imem_ready_i
// DONE  | one-cycle done_o pulse, then back to IDLE
module instr_encoder #(
    parameter int ADDR_W   = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic                fld_valid_i,
    output logic                fld_ready_o,
    input  logic                fld_last_i,
    input  logic [3:0]          op_i,
    input  logic [2:0]          rd_i,
    input  logic [2:0]          rs1_i,
    input  logic [2:0]          rs2_i,
    input  logic [2:0]          funct3_i,
    input  logic [2:0]          funct7_i,
    input  logic [18:0]         imm_i,
    output logic                imem_we_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    output logic [18:0]         imem_wdata_o,
    input  logic                imem_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                rej_o,
    output logic [ERRCNT_W-1:0] rej_cnt_o
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [18:0]         csum_o
`endif
);

    localparam logic [3:0] OP_R_TYPE   = 4'd0;
    localparam logic [3:0] OP_I_TYPE_0 = 4'd1;
    localparam logic [3:0] OP_I_TYPE_1 = 4'd2;
    localparam logic [3:0] OP_I_TYPE_2 = 4'd3;
    localparam logic [3:0] OP_S_TYPE   = 4'd4;
    localparam logic [3:0] OP_B_TYPE   = 4'd5;
    localparam logic [3:0] OP_U_TYPE_0 = 4'd6;
    localparam logic [3:0] OP_U_TYPE_1 = 4'd7;
    localparam logic [3:0] OP_J_TYPE   = 4'd8;
    localparam logic [3:0] OP_C_TYPE   = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [18:0]         wdata_q, wdata_d;
    logic                last_q, last_d;
    logic                rej_q, rej_d;
    logic [ERRCNT_W-1:0] rej_cnt_q, rej_cnt_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [18:0]         csum_q, csum_d;
`endif

    logic [18:0] enc_word;
    logic        enc_legal;

    // Signed ranges are legal when imm_i equals the sign extension of its low bits.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (op_i)
            OP_R_TYPE: begin
                enc_word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
                enc_legal = 1'b1;
            end
            OP_I_TYPE_0, OP_I_TYPE_1, OP_I_TYPE_2: begin
                enc_word  = {imm_i[2:0], rs2_i, rs1_i, funct3_i, rd_i, op_i};
                enc_legal = (imm_i == {{16{imm_i[2]}}, imm_i[2:0]});
            end
            OP_S_TYPE: begin
                enc_word  = {imm_i[8:3], rs1_i, imm_i[2:0], rd_i, op_i};
                enc_legal = (imm_i == {{10{imm_i[8]}}, imm_i[8:0]});
            end
            OP_B_TYPE: begin
                enc_word  = {imm_i[9:4], rs1_i, funct3_i, imm_i[3:1], op_i};
                enc_legal = !imm_i[0] && (imm_i == {{9{imm_i[9]}}, imm_i[9:0]});
            end
            OP_U_TYPE_0, OP_U_TYPE_1: begin
                enc_word  = {imm_i[18:7], rd_i, op_i};
                enc_legal = (imm_i[6:0] == 7'd0);
            end
            OP_J_TYPE: begin
                enc_word  = {imm_i[12:1], rd_i, op_i};
                enc_legal = !imm_i[0] && (imm_i == {{6{imm_i[12]}}, imm_i[12:0]});
            end
            OP_C_TYPE: begin
                enc_word  = {imm_i[14:0], op_i};
                enc_legal = (imm_i[18:15] == 4'd0);
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        last_d    = last_q;
        rej_d     = 1'b0;
        rej_cnt_d = rej_cnt_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = LOAD;
                    addr_d    = base_addr_i;
                    rej_cnt_d = '0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            LOAD: begin
                if (fld_valid_i) begin
                    if (enc_legal) begin
                        wdata_d = enc_word;
                        last_d  = fld_last_i;
                        state_d = WRITE;
                    end else begin
                        rej_d = 1'b1;
                        if (rej_cnt_q != '1) begin
                            rej_cnt_d = rej_cnt_q + ERRCNT_W'(1);
                        end
                        if (fld_last_i) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            WRITE: begin
                if (imem_ready_i) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = last_q ? DONE : LOAD;
`ifdef INSTR_ENCODER_CHECKSUM_EN
                    csum_d  = csum_q ^ wdata_q;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            last_q    <= 1'b0;
            rej_q     <= 1'b0;
            rej_cnt_q <= '0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            last_q    <= last_d;
            rej_q     <= rej_d;
            rej_cnt_q <= rej_cnt_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign fld_ready_o  = (state_q == LOAD);
    assign imem_we_o    = (state_q == WRITE);
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign rej_o        = rej_q;
    assign rej_cnt_o    = rej_cnt_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    assign csum_o       = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding, legality boundaries, stalls, wrap, reset abort.
module tb_instr_encoder;

    localparam int ADDR_W   = 8;
    localparam int ERRCNT_W = 8;

    localparam logic [3:0] R_T  = 4'd0;
    localparam logic [3:0] I0_T = 4'd1;
    localparam logic [3:0] I1_T = 4'd2;
    localparam logic [3:0] I2_T = 4'd3;
    localparam logic [3:0] S_T  = 4'd4;
    localparam logic [3:0] B_T  = 4'd5;
    localparam logic [3:0] U0_T = 4'd6;
    localparam logic [3:0] U1_T = 4'd7;
    localparam logic [3:0] J_T  = 4'd8;
    localparam logic [3:0] C_T  = 4'd9;

    logic                clk = 1'b0;
    logic                reset, start, fld_valid, fld_ready, fld_last;
    logic [ADDR_W-1:0]   base_addr;
    logic [3:0]          op;
    logic [2:0]          rd, rs1, rs2, funct3, funct7;
    logic [18:0]         imm;
    logic                imem_we, imem_ready, busy, done, rej;
    logic [ADDR_W-1:0]   imem_addr;
    logic [18:0]         imem_wdata;
    logic [ERRCNT_W-1:0] rej_cnt;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [18:0]         csum;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_rej;
    logic [ADDR_W-1:0] exp_addr;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .base_addr_i(base_addr),
        .fld_valid_i(fld_valid), .fld_ready_o(fld_ready), .fld_last_i(fld_last),
        .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3),
        .funct7_i(funct7), .imm_i(imm), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
        .imem_wdata_o(imem_wdata), .imem_ready_i(imem_ready), .busy_o(busy),
        .done_o(done), .rej_o(rej), .rej_cnt_o(rej_cnt)
`ifdef INSTR_ENCODER_CHECKSUM_EN
        , .csum_o(csum)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_fields(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [2:0] f3, input logic [2:0] f7,
                              input logic [18:0] im, input logic lst);
        op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im; fld_last = lst;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    // One field set with all register fields zero; legal sets must write `word` at exp_addr.
    task automatic probe(input int idx, input logic [3:0] o, input logic [18:0] im,
                         input logic legal, input logic [18:0] word);
        set_fields(o, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, im, 1'b0);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val($sformatf("probe%0d_we", idx), imem_we, legal);
        check_val($sformatf("probe%0d_rej", idx), rej, !legal);
        if (legal) begin
            check_val($sformatf("probe%0d_data", idx), imem_wdata, word);
            check_val($sformatf("probe%0d_addr", idx), imem_addr, exp_addr);
            tick();
            exp_addr = exp_addr + 8'd1;
        end else begin
            exp_rej++;
            check_val($sformatf("probe%0d_cnt", idx), rej_cnt, exp_rej);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; fld_valid = 1'b0; imem_ready = 1'b1;
        set_fields(R_T, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 19'd0, 1'b0);
        @(negedge clk);
        tick();
        tick();
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_we", imem_we, 1'b0);
        check_val("rst_ready", fld_ready, 1'b0);
        check_val("rst_addr", imem_addr, 8'h00);
        check_val("rst_data", imem_wdata, 19'h0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_rej", rej, 1'b0);
        check_val("rst_cnt", rej_cnt, 8'h00);
        reset = 1'b0;
        tick();
        check_val("idle_ready", fld_ready, 1'b0);

        // Single R-type load
        do_start(8'h10);
        check_val("r_busy", busy, 1'b1);
        check_val("r_ready", fld_ready, 1'b1);
        set_fields(R_T, 3'd3, 3'd1, 3'd2, 3'd0, 3'd0, 19'h7FFFF, 1'b1);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val("r_we", imem_we, 1'b1);
        check_val("r_addr", imem_addr, 8'h10);
        check_val("r_data", imem_wdata, 19'h04430);
        check_val("r_ready_wr", fld_ready, 1'b0);
        tick();
        check_val("r_done", done, 1'b1);
        check_val("r_we_off", imem_we, 1'b0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        check_val("r_csum", csum, 19'h04430);
`endif
        tick();
        check_val("r_done_pulse", done, 1'b0);
        check_val("r_idle", busy, 1'b0);

        // I-type legal/illegal, B-type legal/odd
        do_start(8'h20);
        set_fields(I0_T, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 19'h7FFFF, 1'b0);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val("i_we", imem_we, 1'b1);
        check_val("i_addr", imem_addr, 8'h20);
        check_val("i_data", imem_wdata, 19'h76A11);
        tick();
        set_fields(I0_T, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 19'd4, 1'b0);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val("i4_rej", rej, 1'b1);
        check_val("i4_cnt", rej_cnt, 8'd1);
        check_val("i4_we", imem_we, 1'b0);
        check_val("i4_addr", imem_addr, 8'h21);
        check_val("i4_ready", fld_ready, 1'b1);
        set_fields(B_T, 3'd0, 3'd5, 3'd0, 3'd2, 3'd0, 19'h7FFFE, 1'b0);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val("b_rej_clear", rej, 1'b0);
        check_val("b_we", imem_we, 1'b1);
        check_val("b_addr", imem_addr, 8'h21);
        check_val("b_data", imem_wdata, 19'h7F575);
        tick();
        set_fields(B_T, 3'd0, 3'd5, 3'd0, 3'd2, 3'd0, 19'd3, 1'b1);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val("bodd_rej", rej, 1'b1);
        check_val("bodd_cnt", rej_cnt, 8'd2);
        check_val("bodd_done", done, 1'b1);
        check_val("bodd_we", imem_we, 1'b0);
        tick();
        check_val("bodd_idle", busy, 1'b0);

        // Write stall with a pending field set held valid
        do_start(8'h40);
        imem_ready = 1'b0;
        set_fields(S_T, 3'd7, 3'd6, 3'd0, 3'd0, 3'd0, 19'd100, 1'b0);
        fld_valid = 1'b1;
        tick();
        set_fields(U0_T, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 19'h7FF80, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("stall%0d_we", k), imem_we, 1'b1);
            check_val($sformatf("stall%0d_addr", k), imem_addr, 8'h40);
            check_val($sformatf("stall%0d_data", k), imem_wdata, 19'h19A74);
            check_val($sformatf("stall%0d_ready", k), fld_ready, 1'b0);
            tick();
        end
        imem_ready = 1'b1;
        tick();
        check_val("unstall_ready", fld_ready, 1'b1);
        check_val("unstall_we", imem_we, 1'b0);
        check_val("unstall_addr", imem_addr, 8'h41);
        tick();
        fld_valid = 1'b0;
        check_val("u_we", imem_we, 1'b1);
        check_val("u_addr", imem_addr, 8'h41);
        check_val("u_data", imem_wdata, 19'h7FFA6);
        tick();
        check_val("u_done", done, 1'b1);
        tick();

        // Legality boundaries for every class
        do_start(8'h80);
        exp_addr = 8'h80;
        exp_rej  = 0;
        probe(0,  I0_T, 19'd3,      1'b1, 19'h30001);
        probe(1,  I1_T, 19'h7FFFC,  1'b1, 19'h40002);
        probe(2,  I2_T, 19'h7FFFB,  1'b0, 19'h0);
        probe(3,  S_T,  19'd255,    1'b1, 19'h3E384);
        probe(4,  S_T,  19'h7FF00,  1'b1, 19'h40004);
        probe(5,  S_T,  19'd256,    1'b0, 19'h0);
        probe(6,  B_T,  19'd510,    1'b1, 19'h3E075);
        probe(7,  B_T,  19'h7FE00,  1'b1, 19'h40005);
        probe(8,  B_T,  19'd512,    1'b0, 19'h0);
        probe(9,  U0_T, 19'h00080,  1'b1, 19'h00086);
        probe(10, U1_T, 19'h7FF80,  1'b1, 19'h7FF87);
        probe(11, U0_T, 19'h00001,  1'b0, 19'h0);
        probe(12, J_T,  19'd4094,   1'b1, 19'h3FF88);
        probe(13, J_T,  19'h7F000,  1'b1, 19'h40008);
        probe(14, J_T,  19'd4096,   1'b0, 19'h0);
        probe(15, J_T,  19'd3,      1'b0, 19'h0);
        probe(16, C_T,  19'h07FFF,  1'b1, 19'h7FFF9);
        probe(17, C_T,  19'h08000,  1'b0, 19'h0);
        probe(18, R_T,  19'h7FFFF,  1'b1, 19'h00000);
        probe(19, 4'd10, 19'd0,     1'b0, 19'h0);
        probe(20, 4'd15, 19'd0,     1'b0, 19'h0);

        // Reject counter saturation
        set_fields(4'd15, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 19'd0, 1'b0);
        fld_valid = 1'b1;
        for (int k = 0; k < 250; k++) tick();
        fld_last = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val("sat_cnt", rej_cnt, 8'hFF);
        check_val("sat_done", done, 1'b1);
        tick();

        // Address wrap and counter clear on start
        do_start(8'hFF);
        check_val("wrap_cnt_clr", rej_cnt, 8'h00);
        set_fields(J_T, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 19'h7F000, 1'b0);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val("wrap0_addr", imem_addr, 8'hFF);
        check_val("wrap0_data", imem_wdata, 19'h40018);
        tick();
        set_fields(C_T, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 19'h07FFF, 1'b1);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val("wrap1_we", imem_we, 1'b1);
        check_val("wrap1_addr", imem_addr, 8'h00);
        check_val("wrap1_data", imem_wdata, 19'h7FFF9);
        tick();
        check_val("wrap_done", done, 1'b1);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        check_val("wrap_csum", csum, 19'h40018 ^ 19'h7FFF9);
`endif
        tick();

        // Reset during WRITE
        do_start(8'h30);
        imem_ready = 1'b0;
        set_fields(R_T, 3'd3, 3'd1, 3'd2, 3'd0, 3'd0, 19'd0, 1'b1);
        fld_valid = 1'b1;
        tick();
        fld_valid = 1'b0;
        check_val("abort_pre_we", imem_we, 1'b1);
        reset = 1'b1;
        tick();
        check_val("abort_we", imem_we, 1'b0);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done, 1'b0);
        check_val("abort_addr", imem_addr, 8'h00);
        check_val("abort_ready", fld_ready, 1'b0);
        reset = 1'b0;
        imem_ready = 1'b1;
        tick();
        check_val("abort_no_done", done, 1'b0);
        check_val("abort_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
